// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_pkg
// Brief    : Debug command codes, controller states and memory size encodings
//            shared by the serial front end and the debug controller.
// Revision : 1.0
// ============================================================================
package debug_pkg;

    typedef enum logic [3:0] {
        CMD_NONE     = 4'h0,
        CMD_PAUSE    = 4'h1,
        CMD_RESUME   = 4'h2,
        CMD_RESET    = 4'h3,
        CMD_STATUS   = 4'h4,
        CMD_REG_RD   = 4'h5,
        CMD_REG_WR   = 4'h6,
        CMD_MEM_RD_W = 4'h7,
        CMD_MEM_WR_W = 4'h8,
        CMD_MEM_RD_B = 4'h9,
        CMD_MEM_WR_B = 4'hA
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HALT = 3'd1,
        ST_RST       = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    function automatic logic is_mem_read(cmd_t c);
        return (c == CMD_MEM_RD_W) || (c == CMD_MEM_RD_B);
    endfunction

    function automatic logic is_mem_word(cmd_t c);
        return (c == CMD_MEM_RD_W) || (c == CMD_MEM_WR_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : dbg_wait_counter
// Brief    : Loadable down-counter; expired while the count sits at zero.
// Revision : 1.0
// ============================================================================
module dbg_wait_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/debug_controller.sv
`default_nettype none
// ============================================================================
// Module   : debug_controller
// Brief    : Executes decoded debug commands against the RV32 core, its
//            register file and memory; reports busy, read data and error.
// Revision : 1.0
// ============================================================================
module debug_controller
    import debug_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic        in_valid,
    output logic        ctrlr_busy,
    output logic [31:0] d_rd,
    output logic        error,
    output logic        mcu_pause,
    input  logic        mcu_halted,
    output logic        mcu_reset,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        reg_rd,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_din,
    input  logic [31:0] reg_dout
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT + RESET_CYCLES + MEM_LATENCY) + 1;
    // Every wait loads N-1 so the exit decision lands on the N-th edge.
    localparam logic [CNT_W-1:0] HALT_LOAD  = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_LATENCY - 1);

    state_t      state,      state_nxt;
    cmd_t        cmd_q,      cmd_nxt;
    logic [31:0] addr_q,     addr_nxt;
    logic [31:0] din_q,      din_nxt;
    logic        busy_nxt,   error_nxt,  pause_nxt,  mreset_nxt;
    logic [31:0] d_rd_nxt;
    logic        mem_rd_nxt, mem_we_nxt, reg_rd_nxt, reg_we_nxt;
    logic [1:0]  mem_size_nxt;
    logic [31:0] mem_addr_nxt, mem_din_nxt, reg_din_nxt;
    logic [4:0]  reg_addr_nxt;
    logic             cnt_load, cnt_enable, cnt_expired;
    logic [CNT_W-1:0] cnt_value;
    logic             core_stopped;

    assign core_stopped = mcu_pause && mcu_halted;

    dbg_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (cnt_enable),
        .expired    (cnt_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_q      <= CMD_NONE;
            addr_q     <= '0;
            din_q      <= '0;
            ctrlr_busy <= 1'b0;
            d_rd       <= '0;
            error      <= 1'b0;
            mcu_pause  <= 1'b0;
            mcu_reset  <= 1'b0;
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            reg_rd     <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_din    <= '0;
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            addr_q     <= addr_nxt;
            din_q      <= din_nxt;
            ctrlr_busy <= busy_nxt;
            d_rd       <= d_rd_nxt;
            error      <= error_nxt;
            mcu_pause  <= pause_nxt;
            mcu_reset  <= mreset_nxt;
            mem_rd     <= mem_rd_nxt;
            mem_we     <= mem_we_nxt;
            mem_size   <= mem_size_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_din    <= mem_din_nxt;
            reg_rd     <= reg_rd_nxt;
            reg_we     <= reg_we_nxt;
            reg_addr   <= reg_addr_nxt;
            reg_din    <= reg_din_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd_q;
        addr_nxt     = addr_q;
        din_nxt      = din_q;
        busy_nxt     = ctrlr_busy;
        d_rd_nxt     = d_rd;
        error_nxt    = error;
        pause_nxt    = mcu_pause;
        mreset_nxt   = mcu_reset;
        mem_rd_nxt   = 1'b0;
        mem_we_nxt   = 1'b0;
        mem_size_nxt = mem_size;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        reg_rd_nxt   = 1'b0;
        reg_we_nxt   = 1'b0;
        reg_addr_nxt = reg_addr;
        reg_din_nxt  = reg_din;
        cnt_load     = 1'b0;
        cnt_value    = '0;
        cnt_enable   = 1'b0;

        case (state)
            ST_IDLE: begin
                // IDLE with busy low accepts; IDLE with busy high executes the latched command.
                if (!ctrlr_busy) begin
                    if (in_valid && (cmd != CMD_NONE)) begin
                        cmd_nxt   = cmd_t'(cmd);
                        addr_nxt  = addr;
                        din_nxt   = d_in;
                        d_rd_nxt  = '0;
                        error_nxt = 1'b0;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt = ST_DONE;
                    case (cmd_q)
                        CMD_PAUSE: begin
                            pause_nxt = 1'b1;
                            if (!mcu_halted) begin
                                state_nxt = ST_WAIT_HALT;
                                cnt_load  = 1'b1;
                                cnt_value = HALT_LOAD;
                            end
                        end
                        CMD_RESUME: pause_nxt = 1'b0;
                        CMD_RESET: begin
                            mreset_nxt = 1'b1;
                            state_nxt  = ST_RST;
                            cnt_load   = 1'b1;
                            cnt_value  = RESET_LOAD;
                        end
                        CMD_STATUS: d_rd_nxt = {30'b0, mcu_halted, mcu_pause};
                        CMD_REG_RD, CMD_REG_WR: begin
                            if (core_stopped && (addr_q[31:5] == '0)) begin
                                reg_addr_nxt = addr_q[4:0];
                                if (cmd_q == CMD_REG_RD) begin
                                    reg_rd_nxt = 1'b1;
                                end else begin
                                    reg_we_nxt  = 1'b1;
                                    reg_din_nxt = din_q;
                                end
                            end else begin
                                error_nxt = 1'b1;
                            end
                        end
                        CMD_MEM_RD_W, CMD_MEM_WR_W, CMD_MEM_RD_B, CMD_MEM_WR_B: begin
                            if (core_stopped && (!is_mem_word(cmd_q) || (addr_q[1:0] == 2'b00))) begin
                                mem_addr_nxt = addr_q;
                                mem_size_nxt = is_mem_word(cmd_q) ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
                                if (is_mem_read(cmd_q)) begin
                                    mem_rd_nxt = 1'b1;
                                    state_nxt  = ST_MEM_WAIT;
                                    cnt_load   = 1'b1;
                                    cnt_value  = MEM_LOAD;
                                end else begin
                                    mem_we_nxt  = 1'b1;
                                    mem_din_nxt = din_q;
                                end
                            end else begin
                                error_nxt = 1'b1;
                            end
                        end
                        default: error_nxt = 1'b1;
                    endcase
                end
            end
            ST_WAIT_HALT: begin
                cnt_enable = 1'b1;
                if (mcu_halted) begin
                    state_nxt = ST_DONE;
                end else if (cnt_expired) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_RST: begin
                cnt_enable = 1'b1;
                if (cnt_expired) begin
                    mreset_nxt = 1'b0;
                    state_nxt  = ST_DONE;
                end
            end
            ST_MEM_WAIT: begin
                cnt_enable = 1'b1;
                if (cnt_expired) begin
                    d_rd_nxt  = (mem_size == MEM_SIZE_BYTE) ? {24'b0, mem_dout[7:0]} : mem_dout;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Register reads complete here: reg_dout is valid while reg_rd is high.
                if (reg_rd) begin
                    d_rd_nxt = reg_dout;
                end
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/debug_controller.md
Name: debug_controller

Overview:
Consumes decoded debug commands (cmd/addr/d_in/out_valid) from serial_driver and executes them against the RV32 MCU: pause, resume, reset, status, register-file and memory read/write. Sits directly downstream of serial_driver. Returns ctrlr_busy, d_rd and error to serial_driver so it can build the host reply. Owns all debug-side handshakes with the MCU core and memory.

Parameters:
MEM_LATENCY, 2, cycles from mem_rd pulse to valid mem_dout (1..15)
RESET_CYCLES, 4, length of mcu_reset pulse
HALT_TIMEOUT, 1024, max cycles waiting for mcu_halted after pause

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd  in  4  command code (debug_pkg)
addr  in  32  target address / register index
d_in  in  32  write data
in_valid  in  1  cmd/addr/d_in valid (serial_driver out_valid)
ctrlr_busy  out  1  command in progress
d_rd  out  32  read result / status word
error  out  1  last command failed
mcu_pause  out  1  request core halt (level, sticky)
mcu_halted  in  1  core is halted
mcu_reset  out  1  core reset pulse
mem_rd / mem_we  out  1 each  single-cycle memory strobes
mem_size  out  2  0=byte, 2=word
mem_addr  out  32  memory address
mem_din  out  32  memory write data
mem_dout  in  32  memory read data
reg_rd / reg_we  out  1 each  single-cycle regfile strobes
reg_addr  out  5  register index
reg_din  out  32  register write data
reg_dout  in  32  register read data (combinational, same cycle as reg_rd)

Behaviour:
- Reset: state IDLE; every output 0 (ctrlr_busy, d_rd, error, mcu_pause, mcu_reset, all strobes, addresses, data).
- States: IDLE, WAIT_HALT, RST, MEM_WAIT, DONE.
- IDLE: in_valid && cmd!=NONE -> latch cmd/addr/d_in, clear error, ctrlr_busy=1 next cycle. in_valid ignored while ctrlr_busy=1. cmd=NONE ignored.
- PAUSE: mcu_pause<=1 -> WAIT_HALT; mcu_halted seen -> DONE. HALT_TIMEOUT expiry -> error=1, mcu_pause stays 1, DONE. Already halted -> DONE next cycle.
- RESUME: mcu_pause<=0 -> DONE.
- RESET: mcu_reset=1 for exactly RESET_CYCLES cycles (RST), then DONE; mcu_pause unchanged.
- STATUS: d_rd={30'b0, mcu_halted, mcu_pause} -> DONE.
- REG_RD/REG_WR: require mcu_pause&&mcu_halted and addr[31:5]==0, else error. One-cycle reg_rd (capture reg_dout to d_rd same cycle) or reg_we with reg_din=d_in -> DONE.
- MEM_RD_W/MEM_WR_W/MEM_RD_B/MEM_WR_B: require mcu_pause&&mcu_halted; word forms need addr[1:0]==0, else error. One-cycle strobe. Writes -> DONE. Reads -> MEM_WAIT, count MEM_LATENCY cycles, capture mem_dout (byte reads zero-extend mem_dout[7:0]) -> DONE.
- Error path: no MCU/memory strobe issued; error=1; DONE next cycle. Unknown cmd -> error.
- DONE: one cycle; ctrlr_busy<=0 on exit. d_rd and error hold until next accepted command.
- Strobes never asserted more than one cycle per command.
- Reset mid-command: abort immediately to reset values; no pending strobe completes.
- Total latency, accept to ctrlr_busy fall: RESUME/STATUS/REG/MEM writes 3 cycles; MEM reads 3+MEM_LATENCY.

Decomposition:
- debug_pkg: cmd_t enum (NONE=0, PAUSE=1, RESUME=2, RESET=3, STATUS=4, REG_RD=5, REG_WR=6, MEM_RD_W=7, MEM_WR_W=8, MEM_RD_B=9, MEM_WR_B=A); state_t; mem_size constants. Shared with serial_driver.
- One sub-module: dbg_wait_counter (load/expire down-counter), reused for halt timeout, reset pulse width and memory latency.

Test Plan:
- PAUSE, mcu_halted rises 5 cycles later -> mcu_pause=1, ctrlr_busy high ~6 cycles, error=0; STATUS -> d_rd=0x3.
- MEM_WR_W addr=0x100 d_in=0xDEADBEEF while halted, then MEM_RD_W addr=0x100, model latency 2 -> single mem_we, then d_rd=0xDEADBEEF after 5 busy cycles.
- MEM_RD_W addr=0x102 while halted -> error=1, no mem_rd strobe; MEM_RD_B addr=0x103 with mem_dout=0x12345678 -> d_rd=0x00000078.
- REG_WR addr=5 while not paused -> error=1, reg_we never asserted; REG_RD addr=32 while halted -> error=1.
- PAUSE with mcu_halted held 0 -> error=1 after HALT_TIMEOUT cycles, mcu_pause remains 1; RESET -> mcu_reset high exactly 4 cycles.
- Second in_valid during MEM read -> ignored; reset asserted in MEM_WAIT -> all outputs 0 next cycle, state IDLE.
